isa_io_cycle: RTL and testbench
===============================

ISA_IO_CYCLE -- requirements
Module: isa_io_cycle

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: address/data setup clocks before strobe; legal range 1..15.
REQ-002 Parameter STROBE_CYCLES, default 10: minimum strobe-low clocks; legal range 1..63.
REQ-003 Parameter HOLD_CYCLES, default 2: address/data hold clocks after strobe release; legal range 1..15.
REQ-004 Parameter RDY_TIMEOUT, default 255: maximum extra clocks waiting on IOCHRDY; legal range 1..1023.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-clock request to run a cycle, taken from the control register.
REQ-008 dir  in  1  1 = I/O read (IOR#), 0 = I/O write (IOW#).
REQ-009 addr_in  in  16  I/O address, from the address register.
REQ-010 wdata_in  in  16  write data, from the data register.
REQ-011 isa_sa  out  16  ISA address bus.
REQ-012 isa_sd_out  out  16  ISA data driven on writes.
REQ-013 isa_sd_oe  out  1  data-bus output enable, 1 = drive.
REQ-014 isa_sd_in  in  16  ISA data sampled on reads.
REQ-015 isa_ior_n, isa_iow_n  out  1 each  active-low I/O strobes.
REQ-016 isa_aen  out  1  address enable, 0 during an engine cycle, 1 otherwise.
REQ-017 isa_iochrdy  in  1  asynchronous ready, 0 = extend cycle.
REQ-018 busy  out  1  cycle in progress.
REQ-019 done  out  1  one-clock completion pulse.
REQ-020 timeout  out  1  sticky: last cycle ended by RDY_TIMEOUT.
REQ-021 rdata  out  16  data captured by the last read.

Function
REQ-022 States: IDLE, SETUP, STROBE, WAIT_RDY, HOLD, DONE; one-hot or binary, registered.
REQ-023 IDLE: start=1 latches addr_in, wdata_in and dir, clears timeout, enters SETUP; busy=1 from the next clock.
REQ-024 start while busy=1 is ignored, with no effect on latched values or sequence.
REQ-025 SETUP: isa_sa = latched address, isa_aen=0, both strobes 1; for writes isa_sd_oe=1 with latched data; lasts SETUP_CYCLES clocks.
REQ-026 STROBE: isa_ior_n (read) or isa_iow_n (write) = 0; lasts STROBE_CYCLES clocks; the other strobe stays 1.
REQ-027 isa_iochrdy passes through a 2-flop synchronizer; only the synchronized value is used.
REQ-028 Last STROBE clock: synced ready=1 -> HOLD; otherwise -> WAIT_RDY, strobe held low.
REQ-029 WAIT_RDY: synced ready=1 -> HOLD; after RDY_TIMEOUT clocks without ready -> set timeout=1 and go to HOLD.
REQ-030 Reads: on the transition into HOLD, rdata <= isa_sd_in, including the timeout case.
REQ-031 HOLD: both strobes 1, address/write data/oe unchanged, for HOLD_CYCLES clocks.
REQ-032 DONE: one clock, done=1, isa_sd_oe=0, isa_aen=1, busy=0; next state IDLE.
REQ-033 Unready latency from the start edge: done high in clock 1+SETUP+STROBE+HOLD (15 with defaults).
REQ-034 Strobes, sa, sd_out, oe, aen: driven directly from flops, glitch-free; never both strobes low.
REQ-035 isa_sd_oe is never 1 during a read cycle.
REQ-036 rdata is unchanged by write cycles.

Reset
REQ-037 reset=0 immediately forces IDLE, isa_ior_n=1, isa_iow_n=1, isa_sd_oe=0, isa_aen=1, isa_sa=0, isa_sd_out=0, busy=0, done=0, timeout=0, rdata=0, synchronizer=1.
REQ-038 Reset mid-cycle aborts the cycle, releasing strobes in that same instant, with no done pulse; the first start after release runs a complete cycle.

Verification
REQ-039 Write addr_in=0x0220, wdata_in=0x00A5, ready=1 -> iow_n low clocks 3..12, sa=0x0220, sd_oe=1 clocks 1..14, done at clock 15, ior_n never low.
REQ-040 Read addr 0x0388, isa_sd_in=0x1234, ready=1 -> ior_n low 10 clocks, rdata=0x1234 at done, sd_oe=0 throughout.
REQ-041 Read with iochrdy=0 for 20 clocks from strobe start -> strobe extends until synced ready plus 1 clock, timeout=0, data captured after ready.
REQ-042 iochrdy stuck 0 -> strobe released after 10+255 clocks, timeout=1, done pulses; next start clears timeout.
REQ-043 start pulsed again during STROBE -> ignored, exactly one done; reset=0 in STROBE -> strobes 1 asynchronously, busy=0, no done.

Source files
------------

// File: rtl/isa_io_cycle_if.sv
// Request and ISA bus signals of the I/O cycle engine.
// The master side issues requests and models the ISA target; the slave side is the engine.
interface isa_io_cycle_if;
    logic        start;
    logic        dir;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [15:0] isa_sa;
    logic [15:0] isa_sd_out;
    logic        isa_sd_oe;
    logic [15:0] isa_sd_in;
    logic        isa_ior_n;
    logic        isa_iow_n;
    logic        isa_aen;
    logic        isa_iochrdy;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] rdata;

    modport master (
        output start, dir, addr_in, wdata_in, isa_sd_in, isa_iochrdy,
        input  isa_sa, isa_sd_out, isa_sd_oe, isa_ior_n, isa_iow_n, isa_aen,
               busy, done, timeout, rdata
    );

    modport slave (
        input  start, dir, addr_in, wdata_in, isa_sd_in, isa_iochrdy,
        output isa_sa, isa_sd_out, isa_sd_oe, isa_ior_n, isa_iow_n, isa_aen,
               busy, done, timeout, rdata
    );
endinterface

// File: rtl/isa_io_cycle.sv
// ISA I/O read/write cycle engine: setup, strobe, IOCHRDY wait with timeout, hold, done.
// Every bus-facing output comes straight from a flop so the strobes never glitch.
module isa_io_cycle #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 10,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned RDY_TIMEOUT   = 255
) (
    input logic           clk,
    input logic           reset,
    isa_io_cycle_if.slave bus
);

    localparam int unsigned CntW = 10;

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StWaitRdy, StHold, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              dir_q, dir_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              rdy_s1_q, rdy_s2_q;
    logic              ior_n_q, ior_n_d;
    logic              iow_n_q, iow_n_d;
    logic              sd_oe_q, sd_oe_d;
    logic              aen_q, aen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              active;
    logic              strobing;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dir_d     = dir_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d    = bus.addr_in;
                    wdata_d   = bus.wdata_in;
                    dir_d     = bus.dir;
                    timeout_d = 1'b0;
                    cnt_d     = CntW'(SETUP_CYCLES - 1);
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(STROBE_CYCLES - 1);
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rdy_s2_q) begin
                    cnt_d   = CntW'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end else begin
                    cnt_d   = CntW'(RDY_TIMEOUT - 1);
                    state_d = StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (rdy_s2_q) begin
                    cnt_d   = CntW'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    cnt_d     = CntW'(HOLD_CYCLES - 1);
                    state_d   = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Read data is taken on the strobe-to-hold edge, whether ready or timed out.
        if (state_d == StHold && state_q != StHold && dir_q) begin
            rdata_d = bus.isa_sd_in;
        end

        active   = state_d inside {StSetup, StStrobe, StWaitRdy, StHold};
        strobing = state_d inside {StStrobe, StWaitRdy};
        ior_n_d  = !(strobing && dir_d);
        iow_n_d  = !(strobing && !dir_d);
        sd_oe_d  = active && !dir_d;
        aen_d    = !active;
        busy_d   = active;
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dir_q     <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            rdy_s1_q  <= 1'b1;
            rdy_s2_q  <= 1'b1;
            ior_n_q   <= 1'b1;
            iow_n_q   <= 1'b1;
            sd_oe_q   <= 1'b0;
            aen_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dir_q     <= dir_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            rdy_s1_q  <= bus.isa_iochrdy;
            rdy_s2_q  <= rdy_s1_q;
            ior_n_q   <= ior_n_d;
            iow_n_q   <= iow_n_d;
            sd_oe_q   <= sd_oe_d;
            aen_q     <= aen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.isa_sa     = addr_q;
    assign bus.isa_sd_out = wdata_q;
    assign bus.isa_sd_oe  = sd_oe_q;
    assign bus.isa_ior_n  = ior_n_q;
    assign bus.isa_iow_n  = iow_n_q;
    assign bus.isa_aen    = aen_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_isa_io_cycle.sv
// Directed bench for isa_io_cycle: vector table of whole cycles plus hand-written
// sequences for start-while-busy and reset in the middle of a strobe.
module tb_isa_io_cycle;

    logic clk;
    logic reset;
    isa_io_cycle_if bus ();

    isa_io_cycle dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // rdy_mode: 0 ready always, 1 ready low for clocks 3..22, 2 ready stuck low
    typedef struct {
        logic        dir;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sd_in;
        int          rdy_mode;
        int          exp_first_lo;
        int          exp_lo_cnt;
        int          exp_done;
        int          exp_oe_cnt;
        logic        exp_timeout;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    int          m_first_lo, m_lo_cnt, m_other_lo, m_both, m_oe_cnt, m_aen_lo;
    int          m_done, m_sa_bad, m_sd_bad, m_to_clk1;
    logic        m_timeout, m_busy;
    logic [15:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.dir      = 1'b0;
        bus.addr_in  = 16'h0000;
        bus.wdata_in = 16'h0000;
    endtask

    task automatic run_cycle(input vec_t v);
        logic strobe_n, other_n;
        int   clock;
        bus.isa_iochrdy = (v.rdy_mode == 2) ? 1'b0 : 1'b1;
        bus.isa_sd_in   = (v.rdy_mode == 1) ? ~v.sd_in : v.sd_in;
        repeat (3) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dir      = v.dir;
        bus.addr_in  = v.addr;
        bus.wdata_in = v.wdata;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Disturb the request inputs to prove they were latched.
        bus.dir      = ~v.dir;
        bus.addr_in  = ~v.addr;
        bus.wdata_in = ~v.wdata;
        m_first_lo = 0; m_lo_cnt = 0; m_other_lo = 0; m_both = 0; m_oe_cnt = 0;
        m_aen_lo = 0; m_done = 0; m_sa_bad = 0; m_sd_bad = 0; m_to_clk1 = 0;
        m_timeout = 1'bx; m_busy = 1'bx; m_rdata = 16'hxxxx;
        for (int k = 0; k < 300 && m_done == 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            clock = k + 1;
            if (v.rdy_mode == 1) begin
                bus.isa_iochrdy = !(k >= 2 && k <= 21);
                if (k == 22) bus.isa_sd_in = v.sd_in;
            end
            if (k == 0) m_to_clk1 = int'(bus.timeout);
            strobe_n = v.dir ? bus.isa_ior_n : bus.isa_iow_n;
            other_n  = v.dir ? bus.isa_iow_n : bus.isa_ior_n;
            if (!strobe_n) begin
                if (m_first_lo == 0) m_first_lo = clock;
                m_lo_cnt++;
            end
            if (!other_n) m_other_lo++;
            if (!bus.isa_ior_n && !bus.isa_iow_n) m_both++;
            if (bus.isa_sd_oe) m_oe_cnt++;
            if (!bus.isa_aen) m_aen_lo++;
            if (bus.busy && bus.isa_sa !== v.addr) m_sa_bad++;
            if (bus.busy && !v.dir && bus.isa_sd_out !== v.wdata) m_sd_bad++;
            if (bus.done) begin
                m_done    = clock;
                m_timeout = bus.timeout;
                m_busy    = bus.busy;
                m_rdata   = bus.rdata;
            end
        end
        idle_inputs();
        bus.isa_iochrdy = 1'b1;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        run_cycle(v);
        check({tag, " done_clock"}, m_done, v.exp_done);
        check({tag, " strobe_first"}, m_first_lo, v.exp_first_lo);
        check({tag, " strobe_len"}, m_lo_cnt, v.exp_lo_cnt);
        check({tag, " wrong_strobe"}, m_other_lo, 0);
        check({tag, " both_low"}, m_both, 0);
        check({tag, " oe_clocks"}, m_oe_cnt, v.exp_oe_cnt);
        check({tag, " aen_low_clocks"}, m_aen_lo, v.exp_done - 1);
        check({tag, " sa_stable"}, m_sa_bad, 0);
        check({tag, " sd_out_stable"}, m_sd_bad, 0);
        check({tag, " timeout_cleared"}, m_to_clk1, 0);
        check({tag, " timeout"}, m_timeout, v.exp_timeout);
        check({tag, " busy_at_done"}, m_busy, 1'b0);
        check({tag, " rdata"}, m_rdata, v.exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int dones, dclk, ior_lo, iow_lo, sa_bad;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //              dir   addr      wdata     sd_in    mode first len  done oe   to    rdata
        vecs[0] = '{1'b0, 16'h0220, 16'h00A5, 16'h0000, 0, 3, 10,  15,  14,  1'b0, 16'h0000};
        vecs[1] = '{1'b1, 16'h0388, 16'h0000, 16'h1234, 0, 3, 10,  15,  0,   1'b0, 16'h1234};
        vecs[2] = '{1'b0, 16'h03F8, 16'h5A5A, 16'hAAAA, 0, 3, 10,  15,  14,  1'b0, 16'h1234};
        vecs[3] = '{1'b1, 16'h0300, 16'h0000, 16'hBEEF, 1, 3, 23,  28,  0,   1'b0, 16'hBEEF};
        vecs[4] = '{1'b1, 16'h0060, 16'h0000, 16'hC0DE, 2, 3, 265, 270, 0,   1'b1, 16'hC0DE};
        vecs[5] = '{1'b0, 16'h0080, 16'h1111, 16'h2222, 0, 3, 10,  15,  14,  1'b0, 16'hC0DE};
        vecs[6] = '{1'b0, 16'h0100, 16'hFFFF, 16'h3333, 2, 3, 265, 270, 269, 1'b1, 16'hC0DE};

        idle_inputs();
        bus.isa_sd_in   = 16'h0000;
        bus.isa_iochrdy = 1'b1;
        reset = 1'b0;
        #12;
        check("reset ior_n", bus.isa_ior_n, 1'b1);
        check("reset iow_n", bus.isa_iow_n, 1'b1);
        check("reset sd_oe", bus.isa_sd_oe, 1'b0);
        check("reset aen", bus.isa_aen, 1'b1);
        check("reset sa", bus.isa_sa, 16'h0000);
        check("reset sd_out", bus.isa_sd_out, 16'h0000);
        check("reset busy_done_timeout", {bus.busy, bus.done, bus.timeout}, 3'b000);
        check("reset rdata", bus.rdata, 16'h0000);
        #11;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Second start during STROBE must be ignored.
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dir = 1'b0; bus.addr_in = 16'h0220; bus.wdata_in = 16'h00A5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0; dclk = 0; ior_lo = 0; iow_lo = 0; sa_bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 5) begin
                bus.start = 1'b1; bus.dir = 1'b1; bus.addr_in = 16'h1111; bus.wdata_in = 16'h2222;
            end
            if (k == 6) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (dclk == 0) dclk = k + 1;
            end
            if (!bus.isa_ior_n) ior_lo++;
            if (!bus.isa_iow_n) iow_lo++;
            if (bus.busy && bus.isa_sa !== 16'h0220) sa_bad++;
        end
        idle_inputs();
        check("restart done_count", dones, 1);
        check("restart done_clock", dclk, 15);
        check("restart ior_low", ior_lo, 0);
        check("restart iow_low", iow_lo, 10);
        check("restart sa_stable", sa_bad, 0);
        check("restart sd_out", bus.isa_sd_out, 16'h00A5);

        // Reset asserted mid-strobe aborts at once with no done.
        bus.isa_sd_in = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dir = 1'b1; bus.addr_in = 16'h0388;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort strobe_active", bus.isa_ior_n, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("abort ior_n", bus.isa_ior_n, 1'b1);
        check("abort iow_n", bus.isa_iow_n, 1'b1);
        check("abort busy", bus.busy, 1'b0);
        check("abort aen", bus.isa_aen, 1'b1);
        check("abort rdata", bus.rdata, 16'h0000);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort no_done", dones, 0);
        #2;
        reset = 1'b1;
        check_vec("post_abort", vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
